// File: rtl/prefetch_unit_pkg.sv
// Common types and helpers for the prefetch unit.
//   sof_state_e : tracks whether the next buffered entry opens a fetch stream
//   PC_STEP     : sequential fetch increment in bytes
//   cnt_width   : width of request/stale counters for a given buffer depth
package prefetch_unit_pkg;

   typedef enum logic {
      SOF_FIRST = 1'b0,
      SOF_RUN   = 1'b1
   } sof_state_e;

   localparam int unsigned PC_STEP = 4;

   // One extra bit so a counter can hold the full depth value.
   function automatic int unsigned cnt_width(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// Synchronous instruction-entry FIFO with flush and occupancy output.
// Ports:
//   clk_i, clk_en_i, reset_i : clock, global enable, sync active-high reset
//   flush_i                  : drop all entries (wins over push/pop)
//   push_i, wdata_i          : write an entry (ignored when full, unless popping)
//   pop_i                    : remove head entry (ignored when empty)
//   rdata_o                  : head entry
//   empty_o, count_o         : empty flag and occupancy
module prefetch_fifo #(
   parameter int unsigned C_WIDTH = 8,
   parameter int unsigned C_DEPTH = 4
) (
   input  logic                       clk_i,
   input  logic                       clk_en_i,
   input  logic                       reset_i,
   input  logic                       flush_i,
   input  logic                       push_i,
   input  logic [C_WIDTH-1:0]         wdata_i,
   input  logic                       pop_i,
   output logic [C_WIDTH-1:0]         rdata_o,
   output logic                       empty_o,
   output logic [$clog2(C_DEPTH):0]   count_o
);

   localparam int unsigned AW = $clog2(C_DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [C_WIDTH-1:0] mem_q [C_DEPTH];
   logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]      count_q, count_d;
   logic               full;
   logic               do_push;
   logic               do_pop;

   assign empty_o = (count_q == '0);
   assign full    = (count_q == CW'(C_DEPTH));
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];

   always_comb begin
      do_pop   = pop_i & ~empty_o;
      do_push  = push_i & (~full | do_pop);
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         count_d = count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else if (clk_en_i) begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset; validity is tracked by the pointers.
   always_ff @(posedge clk_i) begin
      if (clk_en_i && do_push && !flush_i) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

endmodule

// File: rtl/riscv_defs.v
// Shared front-end definitions used by the prefetch unit and the id stage.
// SOFID marks the first instruction of a fetch stream (after reset or a
// redirect), so the id stage can tell where a new stream begins.
`ifndef RISCV_DEFS_V
`define RISCV_DEFS_V

`define SOFID_RANGE 1:0
`define SOFID_1ST   2'b01
`define SOFID_RUN   2'b00

`endif

// File: rtl/prefetch_unit.sv
// Instruction prefetch unit: issues sequential word fetches, buffers the
// responses with their PC / error / start-of-fetch id, and redirects on jump.
// Ports:
//   clk_i, clk_en_i, reset_i      : clock, global enable, sync active-high reset
//   ids_*                         : head of instruction buffer to the id stage
//   jump_i, jump_addr_i           : fetch redirect
//   imem_req_*                    : fetch request channel (valid/ready/addr)
//   imem_rsp_*                    : in-order fetch responses, never stalled
//
// Start-of-fetch state:
//   state     | meaning
//   SOF_FIRST | next buffered entry opens a stream, tagged SOFID_1ST
//   SOF_RUN   | next buffered entry continues a stream, tagged SOFID_RUN
`include "riscv_defs.v"

module prefetch_unit
   import prefetch_unit_pkg::*;
#(
   parameter int unsigned        C_XLEN         = 32,
   parameter int unsigned        C_FIFO_DEPTH   = 4,
   parameter logic [C_XLEN-1:0]  C_RESET_VECTOR = 32'h0000_0000
) (
   input  logic                 clk_i,
   input  logic                 clk_en_i,
   input  logic                 reset_i,
   output logic                 ids_dav_o,
   input  logic                 ids_ack_i,
   output logic [`SOFID_RANGE]  ids_sofid_o,
   output logic [31:0]          ids_ins_o,
   output logic                 ids_ferr_o,
   output logic [C_XLEN-1:0]    ids_pc_o,
   input  logic                 jump_i,
   input  logic [C_XLEN-1:0]    jump_addr_i,
   output logic                 imem_req_valid_o,
   input  logic                 imem_req_ready_i,
   output logic [C_XLEN-1:0]    imem_req_addr_o,
   input  logic                 imem_rsp_valid_i,
   input  logic                 imem_rsp_err_i,
   input  logic [31:0]          imem_rsp_data_i
);

   typedef logic [`SOFID_RANGE] sofid_t;

   localparam int unsigned CNT_W   = cnt_width(C_FIFO_DEPTH);
   localparam int unsigned SUM_W   = CNT_W + 2;
   localparam int unsigned SOFID_W = $bits(sofid_t);
   localparam int unsigned ENTRY_W = SOFID_W + 1 + C_XLEN + 32;

   logic [C_XLEN-1:0]  pc_q, pc_d;
   logic               req_valid_q, req_valid_d;
   logic [CNT_W-1:0]   out_q, out_d;
   logic [CNT_W-1:0]   stale_q, stale_d;
   sof_state_e         sof_q, sof_d;

   logic               accept;
   logic               rsp_live;
   logic               rsp_stale;
   logic               push;
   logic               pop;
   logic               flush;
   logic [CNT_W-1:0]   occ;
   logic [CNT_W-1:0]   occ_n;
   logic               fifo_empty;
   logic [ENTRY_W-1:0] fifo_wdata;
   logic [ENTRY_W-1:0] fifo_rdata;
   sofid_t             wr_sofid;
   logic [C_XLEN-1:0]  jump_target;
   logic [SUM_W-1:0]   commit_n;

   assign imem_req_valid_o = req_valid_q;
   assign imem_req_addr_o  = pc_q;
   assign ids_dav_o        = ~fifo_empty;
   assign {ids_sofid_o, ids_ferr_o, ids_pc_o, ids_ins_o} = fifo_rdata;

   assign jump_target = jump_addr_i & {{(C_XLEN-2){1'b1}}, 2'b00};
   assign wr_sofid    = (sof_q == SOF_FIRST) ? `SOFID_1ST : `SOFID_RUN;
   assign fifo_wdata  = {wr_sofid, imem_rsp_err_i, pc_from_rsp(), imem_rsp_data_i};

   // PC of the response being written: the live queue is in order, so the
   // oldest live request sits out_q words behind the current fetch PC.
   function automatic logic [C_XLEN-1:0] pc_from_rsp();
      return pc_q - (C_XLEN'(out_q) << 2);
   endfunction

   always_comb begin
      accept    = req_valid_q & imem_req_ready_i & clk_en_i;
      rsp_stale = imem_rsp_valid_i & (stale_q != '0);
      rsp_live  = imem_rsp_valid_i & (stale_q == '0);
      flush     = clk_en_i & jump_i;
      push      = clk_en_i & rsp_live & ~jump_i;
      pop       = clk_en_i & ids_ack_i & ~fifo_empty & ~jump_i;

      pc_d    = pc_q;
      out_d   = out_q;
      stale_d = stale_q;
      sof_d   = sof_q;
      occ_n   = occ;

      if (jump_i) begin
         // Everything in flight, including this cycle's accept, turns stale;
         // a response arriving now retires one of them either way.
         pc_d    = jump_target;
         out_d   = '0;
         stale_d = stale_q + out_q + CNT_W'(accept) - CNT_W'(imem_rsp_valid_i);
         sof_d   = SOF_FIRST;
         occ_n   = '0;
      end else begin
         if (accept) pc_d = pc_q + C_XLEN'(PC_STEP);
         out_d   = out_q + CNT_W'(accept) - CNT_W'(rsp_live);
         stale_d = stale_q - CNT_W'(rsp_stale);
         if (push) sof_d = SOF_RUN;
         occ_n   = occ + CNT_W'(push) - CNT_W'(pop);
      end

      // Stale requests are included so counters stay within the depth even
      // across back-to-back redirects.
      commit_n    = SUM_W'(occ_n) + SUM_W'(out_d) + SUM_W'(stale_d);
      req_valid_d = (commit_n < SUM_W'(C_FIFO_DEPTH));
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         pc_q        <= C_RESET_VECTOR;
         req_valid_q <= 1'b0;
         out_q       <= '0;
         stale_q     <= '0;
         sof_q       <= SOF_FIRST;
      end else if (clk_en_i) begin
         pc_q        <= pc_d;
         req_valid_q <= req_valid_d;
         out_q       <= out_d;
         stale_q     <= stale_d;
         sof_q       <= sof_d;
      end
   end

   prefetch_fifo #(
      .C_WIDTH (ENTRY_W),
      .C_DEPTH (C_FIFO_DEPTH)
   ) u_fifo (
      .clk_i    (clk_i),
      .clk_en_i (clk_en_i),
      .reset_i  (reset_i),
      .flush_i  (flush),
      .push_i   (push),
      .wdata_i  (fifo_wdata),
      .pop_i    (pop),
      .rdata_o  (fifo_rdata),
      .empty_o  (fifo_empty),
      .count_o  (occ)
   );

endmodule

// File: tb/tb_prefetch_unit.sv
// Directed bench for prefetch_unit: in-order memory model with adjustable
// latency, request/delivery monitors, and hand-computed expectations.
module tb_prefetch_unit;

   localparam logic [1:0] SOF_1ST = 2'b01;
   localparam logic [1:0] SOF_RUN = 2'b00;

   logic        clk = 1'b0;
   logic        clk_en, rst;
   logic        dav, ack;
   logic [1:0]  sofid;
   logic [31:0] ins, pc;
   logic        ferr;
   logic        jump;
   logic [31:0] jump_addr;
   logic        req_valid, req_ready;
   logic [31:0] req_addr;
   logic        rsp_valid, rsp_err;
   logic [31:0] rsp_data;

   // second instance: wrap-around reset vector
   logic        h_rst;
   logic        h_dav;
   logic [1:0]  h_sofid;
   logic [31:0] h_ins, h_pc;
   logic        h_ferr;
   logic        h_req_valid;
   logic [31:0] h_req_addr;
   logic        h_rsp_valid;
   logic [31:0] h_rsp_data;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   prefetch_unit u_dut (
      .clk_i            (clk),
      .clk_en_i         (clk_en),
      .reset_i          (rst),
      .ids_dav_o        (dav),
      .ids_ack_i        (ack),
      .ids_sofid_o      (sofid),
      .ids_ins_o        (ins),
      .ids_ferr_o       (ferr),
      .ids_pc_o         (pc),
      .jump_i           (jump),
      .jump_addr_i      (jump_addr),
      .imem_req_valid_o (req_valid),
      .imem_req_ready_i (req_ready),
      .imem_req_addr_o  (req_addr),
      .imem_rsp_valid_i (rsp_valid),
      .imem_rsp_err_i   (rsp_err),
      .imem_rsp_data_i  (rsp_data)
   );

   prefetch_unit #(.C_RESET_VECTOR(32'hFFFF_FFF8)) u_dut_wrap (
      .clk_i            (clk),
      .clk_en_i         (1'b1),
      .reset_i          (h_rst),
      .ids_dav_o        (h_dav),
      .ids_ack_i        (1'b1),
      .ids_sofid_o      (h_sofid),
      .ids_ins_o        (h_ins),
      .ids_ferr_o       (h_ferr),
      .ids_pc_o         (h_pc),
      .jump_i           (1'b0),
      .jump_addr_i      (32'h0),
      .imem_req_valid_o (h_req_valid),
      .imem_req_ready_i (1'b1),
      .imem_req_addr_o  (h_req_addr),
      .imem_rsp_valid_i (h_rsp_valid),
      .imem_rsp_err_i   (1'b0),
      .imem_rsp_data_i  (h_rsp_data)
   );

   function automatic logic [31:0] ins_of(input logic [31:0] a);
      return a ^ 32'hA5A5_0F0F;
   endfunction

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- memory model (in order, fixed latency) ----------------
   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] due;
   } mreq_t;

   mreq_t       mq[$];
   logic [31:0] mcyc;
   int unsigned lat     = 1;
   logic        err_en  = 1'b0;
   logic [31:0] err_addr = 32'h0;

   always @(posedge clk) begin
      if (rst) begin
         mq.delete();
         mcyc = 0;
         #1 rsp_valid = 1'b0;
      end else if (clk_en) begin
         if (rsp_valid) mq.delete(0);
         mcyc = mcyc + 1;
         if (req_valid && req_ready) mq.push_back('{addr: req_addr, due: mcyc + lat - 1});
         #1;
         if (mq.size() > 0 && mq[0].due <= mcyc) begin
            rsp_valid = 1'b1;
            rsp_data  = ins_of(mq[0].addr);
            rsp_err   = err_en && (mq[0].addr == err_addr);
         end else begin
            rsp_valid = 1'b0;
            rsp_err   = 1'b0;
         end
      end
   end

   // ---------------- monitors ----------------
   typedef struct packed {
      logic [1:0]  sofid;
      logic        ferr;
      logic [31:0] pc;
      logic [31:0] ins;
   } ent_t;

   logic [31:0] req_q[$];
   ent_t        got_q[$];

   always @(posedge clk) begin
      if (!rst && clk_en) begin
         if (req_valid && req_ready) req_q.push_back(req_addr);
         if (dav && ack && !jump) got_q.push_back('{sofid: sofid, ferr: ferr, pc: pc, ins: ins});
      end
   end

   logic [31:0] hreq_q[$];
   logic [31:0] hgot_q[$];
   logic        h_acc;
   logic [31:0] h_a;

   always @(posedge clk) begin
      h_acc = !h_rst && h_req_valid;
      h_a   = h_req_addr;
      if (h_acc) hreq_q.push_back(h_a);
      if (!h_rst && h_dav) hgot_q.push_back(h_pc);
      #1;
      h_rsp_valid = h_acc;
      h_rsp_data  = ins_of(h_a);
   end

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      req_q.delete();
      got_q.delete();
      rst = 1'b0;
   endtask

   int base_req, base_got, s1, s2;

   initial begin
      rst = 1'b1; clk_en = 1'b0; ack = 1'b0; jump = 1'b0; jump_addr = 32'h0;
      req_ready = 1'b1; rsp_valid = 1'b0; rsp_err = 1'b0; rsp_data = 32'h0;
      h_rst = 1'b1; h_rsp_valid = 1'b0; h_rsp_data = 32'h0;

      // reset state, clock enable low
      repeat (3) @(negedge clk);
      check_val("rst_dav",   dav, 0);
      check_val("rst_valid", req_valid, 0);
      check_val("rst_addr",  req_addr, 32'h0);

      // streaming: 1-cycle memory, ack held
      clk_en = 1'b1; ack = 1'b1; lat = 1;
      apply_reset();
      @(negedge clk);
      check_val("first_req_valid", req_valid, 1);
      check_val("first_req_addr",  req_addr, 32'h0);
      repeat (9) @(negedge clk);
      s1 = got_q.size();
      repeat (10) @(negedge clk);
      s2 = got_q.size();
      check_val("throughput", s2 - s1, 10);
      for (int i = 0; i < 4; i++)
         if (req_q.size() > i) check_val("seq_req_addr", req_q[i], 4 * i);
      check_val("seq_got_n", got_q.size() >= 2, 1);
      if (got_q.size() >= 2) begin
         check_val("seq0_pc",    got_q[0].pc, 32'h0);
         check_val("seq0_sofid", got_q[0].sofid, SOF_1ST);
         check_val("seq0_ins",   got_q[0].ins, ins_of(32'h0));
         check_val("seq1_pc",    got_q[1].pc, 32'h4);
         check_val("seq1_sofid", got_q[1].sofid, SOF_RUN);
      end

      // back-pressure: no ack fills exactly four entries
      ack = 1'b0;
      apply_reset();
      repeat (15) @(negedge clk);
      check_val("full_reqs",  req_q.size(), 4);
      check_val("full_dav",   dav, 1);
      check_val("full_valid", req_valid, 0);
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      check_val("free_valid", req_valid, 1);
      repeat (3) @(negedge clk);
      check_val("free_reqs", req_q.size(), 5);
      if (req_q.size() == 5) check_val("free_req_addr", req_q[4], 32'h10);
      if (got_q.size() > 0)  check_val("free_got_pc", got_q[0].pc, 32'h0);

      // redirect with requests in flight
      ack = 1'b1; lat = 4;
      apply_reset();
      repeat (10) @(negedge clk);
      jump = 1'b1; jump_addr = 32'h0000_1002;
      @(negedge clk);
      jump = 1'b0;
      base_req = req_q.size();
      base_got = got_q.size();
      check_val("jump_flush_dav", dav, 0);
      repeat (30) @(negedge clk);
      check_val("jump_reqs", req_q.size() > base_req, 1);
      if (req_q.size() > base_req) check_val("jump_req_addr", req_q[base_req], 32'h1000);
      check_val("jump_got", got_q.size() > base_got + 1, 1);
      if (got_q.size() > base_got + 1) begin
         check_val("jump_pc0",    got_q[base_got].pc, 32'h1000);
         check_val("jump_sofid0", got_q[base_got].sofid, SOF_1ST);
         check_val("jump_ins0",   got_q[base_got].ins, ins_of(32'h1000));
         check_val("jump_pc1",    got_q[base_got+1].pc, 32'h1004);
         check_val("jump_sofid1", got_q[base_got+1].sofid, SOF_RUN);
      end

      // fetch error on address 0x8
      lat = 1; err_en = 1'b1; err_addr = 32'h8;
      apply_reset();
      repeat (15) @(negedge clk);
      err_en = 1'b0;
      check_val("err_got", got_q.size() >= 4, 1);
      if (got_q.size() >= 4) begin
         check_val("err_pc",    got_q[2].pc, 32'h8);
         check_val("err_ferr",  got_q[2].ferr, 1);
         check_val("err_ins",   got_q[2].ins, ins_of(32'h8));
         check_val("next_pc",   got_q[3].pc, 32'hC);
         check_val("next_ferr", got_q[3].ferr, 0);
      end

      // clock enable low for five cycles mid-stream
      apply_reset();
      repeat (6) @(negedge clk);
      clk_en = 1'b0;
      repeat (5) @(negedge clk);
      clk_en = 1'b1;
      repeat (20) @(negedge clk);
      check_val("cen_got", got_q.size() >= 16, 1);
      for (int i = 0; i < 16; i++) begin
         if (got_q.size() > i) check_val("cen_pc", got_q[i].pc, 4 * i);
         if (req_q.size() > i) check_val("cen_req", req_q[i], 4 * i);
      end

      // reset vector near the top of the address space
      @(negedge clk);
      h_rst = 1'b0;
      repeat (10) @(negedge clk);
      check_val("wrap_reqs", hreq_q.size() >= 3, 1);
      check_val("wrap_got",  hgot_q.size() >= 3, 1);
      if (hreq_q.size() >= 3) begin
         check_val("wrap_req0", hreq_q[0], 32'hFFFF_FFF8);
         check_val("wrap_req1", hreq_q[1], 32'hFFFF_FFFC);
         check_val("wrap_req2", hreq_q[2], 32'h0000_0000);
      end
      if (hgot_q.size() >= 3) begin
         check_val("wrap_pc0", hgot_q[0], 32'hFFFF_FFF8);
         check_val("wrap_pc1", hgot_q[1], 32'hFFFF_FFFC);
         check_val("wrap_pc2", hgot_q[2], 32'h0000_0000);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/prefetch_unit.md
PREFETCH_UNIT -- requirements
Module: prefetch_unit

Interface
REQ-001 SHALL take parameter C_XLEN, default 32, as the address/PC width.
REQ-002 SHALL take parameter C_FIFO_DEPTH, default 4 (power of two, >=2), as the number of instruction buffer entries.
REQ-003 SHALL take parameter C_RESET_VECTOR, default 32'h0000_0000, as the first fetch address after reset.
REQ-004 SHALL have one clock; reset is synchronous and active-high.
REQ-005 Ports, in order: clk_i in 1, clock | clk_en_i in 1, global clock enable (no state change when low) | reset_i in 1, synchronous active-high reset.
REQ-006 ids_dav_o out 1, buffered instruction available | ids_ack_i in 1, consumer takes head entry (only honoured when ids_dav_o=1).
REQ-007 ids_sofid_o out `SOFID_RANGE, head start-of-fetch id | ids_ins_o out 32, head instruction | ids_ferr_o out 1, head fetch error | ids_pc_o out C_XLEN, head address.
REQ-008 jump_i in 1, redirect fetch | jump_addr_i in C_XLEN, redirect target.
REQ-009 imem_req_valid_o out 1 | imem_req_ready_i in 1 | imem_req_addr_o out C_XLEN, word-aligned fetch address.
REQ-010 imem_rsp_valid_i in 1 | imem_rsp_err_i in 1 | imem_rsp_data_i in 32; responses in request order, >=1 cycle after acceptance, never back-pressured.

Function
REQ-011 Request accepted when imem_req_valid_o & imem_req_ready_i & clk_en_i; fetch PC then advances by 4, wrapping 0xFFFF_FFFC -> 0x0000_0000.
REQ-012 imem_req_valid_o SHALL be asserted only when (buffer occupancy + live outstanding requests) < C_FIFO_DEPTH, so every live response has a reserved slot.
REQ-013 imem_req_valid_o and imem_req_addr_o SHALL be register-driven; neither depends combinationally on jump_i, ids_ack_i or imem_rsp_*.
REQ-014 A live response SHALL be written to the buffer as {sofid, err, pc, data}; ids_dav_o rises the cycle after the write (1-cycle response-to-dav latency).
REQ-015 ids_dav_o SHALL equal buffer-not-empty; ids_* outputs reflect the head entry; ids_ack_i pops the head; push and pop in the same cycle leave occupancy unchanged.
REQ-016 The first entry fetched after reset or after a jump SHALL carry `SOFID_1ST; all subsequent entries carry `SOFID_RUN.
REQ-017 On jump_i: buffer flushed (ids_dav_o=0 next cycle), fetch PC := {jump_addr_i[C_XLEN-1:2],2'b00}, all outstanding requests including one accepted in the jump cycle become stale.
REQ-018 Stale responses SHALL be counted down and discarded, never written; a response arriving in the jump cycle is discarded.
REQ-019 jump_i has priority over ids_ack_i and a response write in the same cycle.
REQ-020 imem_rsp_err_i=1 SHALL set the entry's ferr; fetching continues sequentially; data is stored unchanged.
REQ-021 Outstanding and stale counters SHALL be ceil(log2(C_FIFO_DEPTH))+1 bits and never exceed C_FIFO_DEPTH.

Reset
REQ-022 While reset_i=1 at a clock edge: ids_dav_o=0, imem_req_valid_o=0, imem_req_addr_o=C_RESET_VECTOR, buffer empty, counters 0, sofid state=`SOFID_1ST; clk_en_i is not required.
REQ-023 First request SHALL assert in the first cycle after reset_i deasserts; reset mid-operation drops all entries and outstanding requests; the memory side is reset together.

Structure
REQ-024 `SOFID_RANGE, `SOFID_1ST and `SOFID_RUN SHALL live in riscv_defs.v, shared with the id stage.
REQ-025 The entry buffer SHALL be one sub-module, prefetch_fifo (sync FIFO, flush input, occupancy output); request/credit/stale logic stays in prefetch_unit.

Verification
REQ-026 Reset, ready=1, 1-cycle memory, ack=1 -> requests 0x0,0x4,0x8...; first entry sofid=1ST, then RUN; one instruction per cycle sustained.
REQ-027 ack=0 held -> exactly 4 entries buffered, imem_req_valid_o=0 until an ack frees a slot.
REQ-028 3 requests outstanding, jump_i to 0x1002 -> next request addr 0x1000, 3 stale responses dropped, first delivered pc=0x1000 sofid=1ST.
REQ-029 imem_rsp_err_i=1 on fetch at 0x8 -> entry pc=0x8 ferr=1, next entry pc=0xC ferr=0.
REQ-030 C_RESET_VECTOR=0xFFFF_FFF8 -> pcs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-031 clk_en_i=0 for 5 cycles mid-stream -> no state or output change; stream resumes without loss or duplication.
